counter8_ctrl: RTL and testbench

Sequencing controller for the team's 8-bit loadable counter (counter8clr).
- Drives the counter's clear/load/start_stop/data controls.
- Watches the counter's count output and stops or reloads the run when count reaches a programmed terminal value.
- Supports pause/resume, abort, and one-shot or auto-reload operation, giving the counter a command-level interface for timer and stopwatch use.

---
 rtl/counter8_ctrl.sv | 151 +++++++++++++++
 tb/tb_counter8_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter8_ctrl.sv
// counter8_ctrl: command-level sequencer for the 8-bit loadable counter.
// It drives the counter's clear/load/enable/data controls and watches count_in
// against a terminal value latched at run start. Supported operations are
// one-shot or auto-reload runs, pause/resume and abort.
module counter8_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] terminal,
    input  logic [WIDTH-1:0] count_in,
    output logic             cnt_clear,
    output logic             cnt_load,
    output logic             cnt_start_stop,
    output logic [WIDTH-1:0] cnt_data,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic [7:0]       reload_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             ar_q, ar_d;
    logic             done_q, done_d;
    logic [7:0]       reload_cnt_q, reload_cnt_d;
    logic             clr_q, clr_d;
    logic             ld_q, ld_d;
    logic             busy_q, busy_d;
    logic             paused_q, paused_d;
    logic             match_s;

    assign match_s = (count_in == term_q);

    // Increment enable is combinational so the counter never steps past the
    // terminal value, past a stop, or during the abort cycle.
    assign cnt_start_stop = (state_q == S_RUN) & ~match_s & ~stop & ~abort;

    assign cnt_clear  = clr_q;
    assign cnt_load   = ld_q;
    assign cnt_data   = load_q;
    assign busy       = busy_q;
    assign paused     = paused_q;
    assign done       = done_q;
    assign reload_cnt = reload_cnt_q;

    // Next-state, run-parameter latching and registered output decode.
    always_comb begin
        state_d      = state_q;
        load_d       = load_q;
        term_d       = term_q;
        ar_d         = ar_q;
        done_d       = 1'b0;
        reload_cnt_d = reload_cnt_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d      = S_LOAD;
                        load_d       = load_value;
                        term_d       = terminal;
                        ar_d         = auto_reload;
                        reload_cnt_d = 8'd0;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_LOAD: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    // A terminal match wins over a simultaneous stop.
                    if (match_s) begin
                        done_d = 1'b1;
                        if (ar_q) begin
                            state_d      = S_LOAD;
                            reload_cnt_d = (reload_cnt_q == 8'hFF) ? 8'hFF
                                                                   : reload_cnt_q + 8'd1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (stop) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        // Moore outputs are registered from the next state, so they change on
        // the same edge as the state register.
        clr_d    = (state_d == S_IDLE);
        ld_d     = (state_d == S_LOAD);
        busy_d   = (state_d == S_LOAD) | (state_d == S_RUN) | (state_d == S_PAUSE);
        paused_d = (state_d == S_PAUSE);
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= S_IDLE;
            load_q       <= '0;
            term_q       <= '0;
            ar_q         <= 1'b0;
            done_q       <= 1'b0;
            reload_cnt_q <= 8'd0;
            clr_q        <= 1'b1;
            ld_q         <= 1'b0;
            busy_q       <= 1'b0;
            paused_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_q       <= load_d;
            term_q       <= term_d;
            ar_q         <= ar_d;
            done_q       <= done_d;
            reload_cnt_q <= reload_cnt_d;
            clr_q        <= clr_d;
            ld_q         <= ld_d;
            busy_q       <= busy_d;
            paused_q     <= paused_d;
        end
    end

endmodule

// File: tb/tb_counter8_ctrl.sv
// Testbench for counter8_ctrl. The DUT drives a behavioural counter, and that
// counter's count is fed back to the DUT. Each cycle is checked against a
// run-level reference model. The model tracks a step count against the
// increment distance N = (terminal - load) mod 256.
module tb_counter8_ctrl;

    logic       clock;
    logic       clear_i, start_i, stop_i, abort_i, ar_i;
    logic [7:0] load_i, term_i;
    logic [7:0] count_q;
    logic       cnt_clear, cnt_load, cnt_start_stop, busy, paused, done;
    logic [7:0] cnt_data, reload_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit         m_valid = 1'b0;
    bit         m_loading, m_running, m_paused, m_finished, m_done, m_ar;
    logic [7:0] m_load, m_term, m_n, m_steps, m_count, m_rc;
    int         cyc = 0;

    counter8_ctrl #(.WIDTH(8)) dut (
        .clock(clock), .clear(clear_i), .start(start_i), .stop(stop_i),
        .abort(abort_i), .auto_reload(ar_i), .load_value(load_i),
        .terminal(term_i), .count_in(count_q), .cnt_clear(cnt_clear),
        .cnt_load(cnt_load), .cnt_start_stop(cnt_start_stop),
        .cnt_data(cnt_data), .busy(busy), .paused(paused), .done(done),
        .reload_cnt(reload_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // The counter8clr being sequenced; the system clear is shared with it.
    always_ff @(posedge clock) begin
        if (clear_i || cnt_clear) count_q <= 8'd0;
        else if (cnt_load)        count_q <= cnt_data;
        else if (cnt_start_stop)  count_q <= count_q + 8'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle with the current inputs, plus model update and checks.
    task automatic tick();
        bit exp_ss, was_idle;
        exp_ss = m_running && (m_steps != m_n) && !stop_i && !abort_i;
        #1;
        if (m_valid) check_eq("cnt_start_stop", cnt_start_stop, exp_ss);
        @(posedge clock);
        cyc++;
        was_idle = !(m_loading || m_running || m_paused || m_finished);
        if (clear_i || (m_valid && was_idle)) m_count = 8'd0;
        else if (m_loading)                   m_count = m_load;
        else if (exp_ss)                      m_count = m_count + 8'd1;
        if (clear_i) begin
            {m_loading, m_running, m_paused, m_finished, m_done, m_ar} = '0;
            m_load = 8'd0; m_term = 8'd0; m_n = 8'd0; m_steps = 8'd0; m_rc = 8'd0;
            m_count = 8'd0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_done = 1'b0;
            if (abort_i) begin
                {m_loading, m_running, m_paused, m_finished} = '0;
            end else if (was_idle || m_finished) begin
                if (start_i) begin
                    m_finished = 1'b0; m_loading = 1'b1;
                    m_load = load_i; m_term = term_i; m_ar = ar_i;
                    m_n = term_i - load_i; m_rc = 8'd0;
                end
            end else if (m_loading) begin
                m_loading = 1'b0; m_running = 1'b1; m_steps = 8'd0;
            end else if (m_running) begin
                if (m_steps == m_n) begin
                    m_running = 1'b0; m_done = 1'b1;
                    if (m_ar) begin
                        m_loading = 1'b1;
                        if (m_rc != 8'd255) m_rc = m_rc + 8'd1;
                    end else m_finished = 1'b1;
                end else if (stop_i) begin
                    m_running = 1'b0; m_paused = 1'b1;
                end else m_steps = m_steps + 8'd1;
            end else if (m_paused) begin
                if (start_i) begin
                    m_paused = 1'b0; m_running = 1'b1;
                end
            end
        end
        @(negedge clock);
        if (m_valid) begin
            check_eq("cnt_clear", cnt_clear,
                     !(m_loading || m_running || m_paused || m_finished));
            check_eq("cnt_load", cnt_load, m_loading);
            check_eq("cnt_data", cnt_data, m_load);
            check_eq("busy", busy, m_loading || m_running || m_paused);
            check_eq("paused", paused, m_paused);
            check_eq("done", done, m_done);
            check_eq("reload_cnt", reload_cnt, m_rc);
            check_eq("count", count_q, m_count);
        end
    endtask

    task automatic idle_inputs();
        {clear_i, start_i, stop_i, abort_i} = '0;
    endtask

    task automatic begin_run(input logic [7:0] lv, input logic [7:0] tv, input logic ar);
        load_i = lv; term_i = tv; ar_i = ar; start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        int done_cyc[$];
        int k;
        idle_inputs();
        ar_i = 1'b0; load_i = 8'd0; term_i = 8'd0;
        @(negedge clock);

        // reset then idle
        clear_i = 1'b1; tick(); tick(); clear_i = 1'b0;
        check_eq("rst_cnt_clear", cnt_clear, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_reload", reload_cnt, 8'd0);
        check_eq("rst_count", count_q, 8'd0);
        tick();

        // one-shot 5 -> 10: done after E7
        begin_run(8'd5, 8'd10, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check_eq("os_count10", count_q, 8'd10);
        check_eq("os_done_early", done, 1'b0);
        tick();
        check_eq("os_done_e7", done, 1'b1);
        check_eq("os_busy", busy, 1'b0);
        tick();
        check_eq("os_hold", count_q, 8'd10);
        check_eq("os_done_pulse", done, 1'b0);

        // load == terminal: done at E2
        begin_run(8'd9, 8'd9, 1'b0);
        tick(); tick();
        check_eq("eq_done_e2", done, 1'b1);
        check_eq("eq_count", count_q, 8'd9);

        // pause / resume, 0 -> 20
        begin_run(8'd0, 8'd20, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        check_eq("pz_count7", count_q, 8'd7);
        stop_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        stop_i = 1'b0;
        check_eq("pz_paused", paused, 1'b1);
        check_eq("pz_hold7", count_q, 8'd7);
        start_i = 1'b1; stop_i = 1'b1; tick(); start_i = 1'b0; stop_i = 1'b0;
        check_eq("pz_resumed", paused, 1'b0);
        tick();
        check_eq("pz_count8", count_q, 8'd8);
        k = 0;
        while (done !== 1'b1 && k < 40) begin tick(); k++; end
        check_eq("pz_done_wait", k, 13);

        // wrap and auto-reload 250 -> 3, period 11
        begin_run(8'd250, 8'd3, 1'b1);
        for (int i = 0; i < 36; i++) begin
            tick();
            if (done === 1'b1) done_cyc.push_back(cyc);
        end
        check_eq("ar_pulses", done_cyc.size(), 3);
        if (done_cyc.size() >= 3) begin
            check_eq("ar_period1", done_cyc[1] - done_cyc[0], 11);
            check_eq("ar_period2", done_cyc[2] - done_cyc[1], 11);
        end
        check_eq("ar_reload3", reload_cnt, 8'd3);
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        check_eq("ab_busy", busy, 1'b0);
        tick();
        check_eq("ab_count0", count_q, 8'd0);

        // stop coincident with match -> done, not pause
        begin_run(8'd1, 8'd3, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        check_eq("sm_done", done, 1'b1);
        check_eq("sm_not_paused", paused, 1'b0);

        // start during run ignored, then clear mid-run
        begin_run(8'd0, 8'd50, 1'b0);
        start_i = 1'b1; load_i = 8'd99;
        for (int i = 0; i < 5; i++) tick();
        start_i = 1'b0;
        check_eq("sr_count", count_q, 8'd4);
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        check_eq("cl_cnt_clear", cnt_clear, 1'b1);
        check_eq("cl_busy", busy, 1'b0);
        check_eq("cl_count", count_q, 8'd0);
        check_eq("cl_data", cnt_data, 8'd0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            clear_i = ($urandom_range(0, 299) == 0);
            abort_i = ($urandom_range(0, 79) == 0);
            start_i = ($urandom_range(0, 5) == 0);
            stop_i  = ($urandom_range(0, 6) == 0);
            ar_i    = $urandom_range(0, 1);
            load_i  = $urandom_range(0, 255);
            term_i  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                  : load_i + 8'($urandom_range(0, 12));
            tick();
        end
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
